calib_scan_ctrl: RTL

- Column-scan sequencer for the pixel-calibration and main-work datapath.
- Generates the shared column select `cnt_column_sys`, the per-column `flag_col` strobe, the `finish_frame` strobe and the `cs_pixel_calib` enable consumed by the pixel calibration block.
- Supports full-array and half-array scans, a programmable per-column dwell, a frame-count timeout and abort.
- Sits between the command decoder (st_pixel_calib / st_main_work) and the pixel array.

---
 rtl/calib_scan_if.sv | 33 +++
 rtl/calib_scan_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/calib_scan_if.sv
// Control/status bundle between the command decoder, the column-scan sequencer
// and the pixel-calibration block.
interface calib_scan_if #(
  parameter int unsigned CNT_COL    = 4,
  parameter int unsigned BITS_FRAME = 16
);
  logic                  start;
  logic                  abort;
  logic [1:0]            mode;
  logic [7:0]            dwell;
  logic [BITS_FRAME-1:0] max_frames;
  logic                  finish_pixel_calib;
  logic                  cs_pixel_calib;
  logic [CNT_COL-1:0]    cnt_column_sys;
  logic                  flag_col;
  logic                  finish_frame;
  logic [BITS_FRAME-1:0] frame_count;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, abort, mode, dwell, max_frames, finish_pixel_calib,
    input  cs_pixel_calib, cnt_column_sys, flag_col, finish_frame,
           frame_count, busy, done, err
  );

  modport slave (
    input  start, abort, mode, dwell, max_frames, finish_pixel_calib,
    output cs_pixel_calib, cnt_column_sys, flag_col, finish_frame,
           frame_count, busy, done, err
  );
endinterface

// File: rtl/calib_scan_ctrl.sv
// Column-scan sequencer: settles the calibration enable, then walks the column
// select across the full or half array with a programmable dwell per column.
module calib_scan_ctrl #(
  parameter int unsigned NUM_COL    = 16,
  parameter int unsigned CNT_COL    = 4,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned BITS_FRAME = 16
) (
  input logic         clk,
  input logic         rst,
  calib_scan_if.slave bus
);

  localparam int unsigned HALF  = NUM_COL / 2;
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SCAN   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                state_q, state_n;
  logic [SET_W-1:0]      settle_q, settle_n;
  logic [7:0]            dwell_q, dwell_n;
  logic [7:0]            dlast_q, dlast_n;
  logic [CNT_COL-1:0]    col_q, col_n;
  logic [BITS_FRAME-1:0] frame_q, frame_n, frame_inc;
  logic [BITS_FRAME-1:0] max_q, max_n;
  logic [1:0]            mode_q, mode_n;
  logic                  wrap;

  logic                  busy_q, busy_n;
  logic [CNT_COL-1:0]    col_out_q, col_out_n;
  logic                  flag_q, flag_n;
  logic                  ff_q, ff_n;
  logic                  done_q, done_n;
  logic                  err_q, err_n;

  function automatic logic [CNT_COL-1:0] col_lo(input logic [1:0] m);
    return (m == 2'b10) ? CNT_COL'(HALF) : '0;
  endfunction

  function automatic logic [CNT_COL-1:0] col_hi(input logic [1:0] m);
    return (m == 2'b01) ? CNT_COL'(HALF - 1) : CNT_COL'(NUM_COL - 1);
  endfunction

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      dwell_q   <= '0;
      dlast_q   <= '0;
      col_q     <= '0;
      frame_q   <= '0;
      max_q     <= '0;
      mode_q    <= '0;
      busy_q    <= 1'b0;
      col_out_q <= '0;
      flag_q    <= 1'b0;
      ff_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      settle_q  <= settle_n;
      dwell_q   <= dwell_n;
      dlast_q   <= dlast_n;
      col_q     <= col_n;
      frame_q   <= frame_n;
      max_q     <= max_n;
      mode_q    <= mode_n;
      busy_q    <= busy_n;
      col_out_q <= col_out_n;
      flag_q    <= flag_n;
      ff_q      <= ff_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  // Next state; outputs are decoded from the next-cycle values so they register cleanly
  always_comb begin
    state_n   = state_q;
    settle_n  = settle_q;
    dwell_n   = dwell_q;
    dlast_n   = dlast_q;
    col_n     = col_q;
    frame_n   = frame_q;
    max_n     = max_q;
    mode_n    = mode_q;
    err_n     = 1'b0;
    wrap      = 1'b0;
    frame_inc = (frame_q == '1) ? frame_q : frame_q + BITS_FRAME'(1);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.mode == 2'b11) begin
            err_n = 1'b1;
          end else begin
            mode_n   = bus.mode;
            dlast_n  = (bus.dwell == 8'd0) ? 8'd0 : bus.dwell - 8'd1;
            max_n    = bus.max_frames;
            frame_n  = '0;
            settle_n = '0;
            dwell_n  = '0;
            col_n    = col_lo(bus.mode);
            state_n  = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
          frame_n = '0;
        end else if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          state_n = ST_SCAN;
          dwell_n = '0;
        end else begin
          settle_n = settle_q + SET_W'(1);
        end
      end
      ST_SCAN: begin
        // Last dwell cycle of the last column closes a frame
        wrap = (dwell_q == dlast_q) && (col_q == col_hi(mode_q));
        if (wrap) frame_n = frame_inc;
        if (bus.abort) begin
          state_n = ST_IDLE;
          frame_n = '0;
        end else if (bus.finish_pixel_calib) begin
          state_n = ST_DONE;
        end else if (wrap && (max_q != '0) && (frame_inc == max_q)) begin
          state_n = ST_DONE;
          err_n   = 1'b1;
        end else if (dwell_q == dlast_q) begin
          dwell_n = '0;
          col_n   = (col_q == col_hi(mode_q)) ? col_lo(mode_q) : col_q + CNT_COL'(1);
        end else begin
          dwell_n = dwell_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        if (bus.abort) frame_n = '0;
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n    = (state_n == ST_SETTLE) || (state_n == ST_SCAN);
    col_out_n = busy_n ? col_n : '0;
    flag_n    = (state_n == ST_SCAN) && (dwell_n == dlast_n);
    ff_n      = flag_n && (col_n == col_hi(mode_n));
    done_n    = (state_n == ST_DONE);
  end

  assign bus.cs_pixel_calib = busy_q;
  assign bus.busy           = busy_q;
  assign bus.cnt_column_sys = col_out_q;
  assign bus.flag_col       = flag_q;
  assign bus.finish_frame   = ff_q;
  assign bus.frame_count    = frame_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;

endmodule
